// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: request/response bundle between the ALU lane
// and the multi-cycle multiply/divide engine.
interface ex_muldiv_unit_if #(
   parameter int DATA_W = 32
);
   logic                  start_i;
   logic [2:0]            op_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic [DATA_W-1:0]     hi_i;
   logic [DATA_W-1:0]     lo_i;
   logic                  flush_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;
   logic                  busy_o;
   logic                  div_by_zero_o;
   logic                  stallreq_o;

   modport master (
      output start_i, op_i, opdata1_i, opdata2_i,
      output hi_i, lo_i, flush_i,
      input  result_o, ready_o, busy_o,
      input  div_by_zero_o, stallreq_o
   );

   modport slave (
      input  start_i, op_i, opdata1_i, opdata2_i,
      input  hi_i, lo_i, flush_i,
      output result_o, ready_o, busy_o,
      output div_by_zero_o, stallreq_o
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: unified multi-cycle MULT/DIV engine for the EX stage.
// Define MULDIV_MADD_EN to enable the MADD/MSUB accumulate ops.
module ex_muldiv_unit #(
   parameter int DATA_W     = 32,
   parameter int MUL_STAGES = 2
) (
   input logic              clk,
   input logic              rst,
   ex_muldiv_unit_if.slave  bus
);
   localparam int W  = DATA_W;
   localparam int W2 = 2 * DATA_W;
   localparam int CW = $clog2(DATA_W) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [W2-1:0] prod_q;
   logic [W2-1:0] result_q;
   logic          dbz_q;
   logic [W-1:0]  rem_q;
   logic [W-1:0]  quo_q;
   logic [W-1:0]  dvs_q;
   logic          negq_q;
   logic          negr_q;

   logic          sgn;
   logic          legal;
   logic          is_div;
   logic          accept;
   logic          a_neg;
   logic          b_neg;
   logic [W-1:0]  mag_a;
   logic [W-1:0]  mag_b;
   logic [W2-1:0] a_ext;
   logic [W2-1:0] b_ext;
   logic [W2-1:0] prod;
   logic [W2-1:0] mul_val;
   logic [W2-1:0] step_first;
   logic [W2-1:0] step_run;
   logic [W-1:0]  q_fin;
   logic [W-1:0]  r_fin;

   // One restoring step: returns {remainder, shifted quotient}.
   function automatic logic [W2-1:0] div_step(
      input logic [W-1:0] rem,
      input logic [W-1:0] quo,
      input logic [W-1:0] dvs
   );
      logic [W:0] sh;
      logic [W:0] diff;
      logic       qb;
      sh   = {rem, quo[W-1]};
      diff = sh - {1'b0, dvs};
      qb   = (sh >= {1'b0, dvs});
      if (qb) sh = diff;
      return {sh[W-1:0], quo[W-2:0], qb};
   endfunction

   // Decode, operand magnitudes, product and divider datapath.
   always_comb begin
      sgn    = ~bus.op_i[0];
`ifdef MULDIV_MADD_EN
      legal  = 1'b1;
`else
      legal  = ~bus.op_i[2];
`endif
      is_div = ~bus.op_i[2] & bus.op_i[1];
      accept = (state == S_IDLE) & bus.start_i
             & legal & ~bus.flush_i;
      a_neg  = sgn & bus.opdata1_i[W-1];
      b_neg  = sgn & bus.opdata2_i[W-1];
      mag_a  = a_neg ? -bus.opdata1_i : bus.opdata1_i;
      mag_b  = b_neg ? -bus.opdata2_i : bus.opdata2_i;
      a_ext  = {{W{a_neg}}, bus.opdata1_i};
      b_ext  = {{W{b_neg}}, bus.opdata2_i};
      prod   = a_ext * b_ext;
      mul_val = prod;
`ifdef MULDIV_MADD_EN
      if (bus.op_i[2]) begin
         if (bus.op_i[1])
            mul_val = {bus.hi_i, bus.lo_i} - prod;
         else
            mul_val = {bus.hi_i, bus.lo_i} + prod;
      end
`endif
      step_first = div_step('0, mag_a, mag_b);
      step_run   = div_step(rem_q, quo_q, dvs_q);
      q_fin = negq_q ? -step_run[W-1:0] : step_run[W-1:0];
      r_fin = negr_q ? -step_run[W2-1:W] : step_run[W2-1:W];
   end

   assign bus.ready_o       = (state == S_DONE) & ~bus.flush_i;
   assign bus.busy_o        = (state != S_IDLE);
   assign bus.result_o      = result_q;
   assign bus.div_by_zero_o = dbz_q;
   // Stall request is held low while in reset.
   assign bus.stallreq_o    = ((bus.start_i & legal) | bus.busy_o)
                            & ~bus.ready_o & ~bus.flush_i & rst;

   // FSM, latency counter, divider state and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         prod_q   <= '0;
         result_q <= '0;
         dbz_q    <= 1'b0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
      end else if (bus.flush_i) begin
         state <= S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept && is_div) begin
                  if (bus.opdata2_i == '0) begin
                     state    <= S_DONE;
                     result_q <= {bus.opdata1_i, {W{1'b1}}};
                     dbz_q    <= 1'b1;
                  end else begin
                     state  <= S_DIV;
                     cnt    <= CW'(W - 1);
                     rem_q  <= step_first[W2-1:W];
                     quo_q  <= step_first[W-1:0];
                     dvs_q  <= mag_b;
                     negq_q <= a_neg ^ b_neg;
                     negr_q <= a_neg;
                  end
               end else if (accept) begin
                  if (MUL_STAGES == 1) begin
                     state    <= S_DONE;
                     result_q <= mul_val;
                     dbz_q    <= 1'b0;
                  end else begin
                     state  <= S_MUL;
                     prod_q <= mul_val;
                     cnt    <= CW'(MUL_STAGES - 1);
                  end
               end
            end
            S_MUL: begin
               if (cnt == CW'(1)) begin
                  state    <= S_DONE;
                  result_q <= prod_q;
                  dbz_q    <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_DIV: begin
               rem_q <= step_run[W2-1:W];
               quo_q <= step_run[W-1:0];
               if (cnt == CW'(1)) begin
                  state    <= S_DONE;
                  result_q <= {r_fin, q_fin};
                  dbz_q    <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
